activation_lut_scheduler: RTL and testbench

Controller for the shared activation LUT BRAM (single read port, single write port). It sequences one activation pass on request: it snapshots NUM_NEURON LUT addresses, issues one BRAM read per cycle and collects the returned values into a packed result vector. It then signals completion with a done pulse. It also arbitrates host configuration writes into the LUT, which are accepted only while no pass is in flight.

---
 rtl/activation_pkg.sv | 37 +++
 rtl/activation_rd_pipe.sv | 44 ++++
 rtl/activation_lut_scheduler.sv | 143 ++++++++++++++
 tb/tb_activation_lut_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// ============================================================================
// Module      : activation_pkg
// Description : Shared types and helpers for the activation LUT scheduler:
//               pass state encoding, clog2 helper and read-latency bounds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package activation_pkg;

  // Pass sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Supported BRAM read latency range
  localparam int c_READ_LATENCY_MIN = 1;
  localparam int c_READ_LATENCY_MAX = 4;

  // Ceiling log2 with a fixed loop bound so it stays elaboration friendly
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/activation_rd_pipe.sv
// ============================================================================
// Module      : activation_rd_pipe
// Description : READ_LATENCY-deep shift register carrying {valid, index} so
//               each returned BRAM word can be steered to its neuron slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module activation_rd_pipe #(
  parameter int READ_LATENCY = 1,
  parameter int IDX_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             capture_valid,
  output logic [IDX_W-1:0] capture_idx
);

  logic [READ_LATENCY-1:0]            r_valid;
  logic [READ_LATENCY-1:0][IDX_W-1:0] r_idx;

  // Shift the read tag along with the BRAM latency; reset flushes all tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_idx   <= '0;
    end else begin
      r_valid[0] <= issue_valid;
      r_idx[0]   <= issue_idx;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_idx[s]   <= r_idx[s-1];
      end
    end
  end

  assign capture_valid = r_valid[READ_LATENCY-1];
  assign capture_idx   = r_idx[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/activation_lut_scheduler.sv
// ============================================================================
// Module      : activation_lut_scheduler
// Description : Sequences one activation pass through the shared LUT BRAM
//               (one read per cycle, results packed per neuron) and
//               arbitrates host configuration writes while idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module activation_lut_scheduler
  import activation_pkg::*;
#(
  parameter int NUM_NEURON    = 6,
  parameter int LUT_ADDR_SIZE = 10,
  parameter int LUT_WIDTH     = 9,
  parameter int READ_LATENCY  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_NEURON*LUT_ADDR_SIZE-1:0] inputs,
  output logic                               busy,
  output logic                               done,
  output logic [NUM_NEURON*LUT_WIDTH-1:0]    outputs,
  output logic                               lut_rd_en,
  output logic [LUT_ADDR_SIZE-1:0]           lut_rd_addr,
  input  logic [LUT_WIDTH-1:0]               lut_rd_data,
  input  logic                               cfg_wr_valid,
  output logic                               cfg_wr_ready,
  input  logic [LUT_ADDR_SIZE-1:0]           cfg_wr_addr,
  input  logic [LUT_WIDTH-1:0]               cfg_wr_data,
  output logic                               lut_wr_en,
  output logic [LUT_ADDR_SIZE-1:0]           lut_wr_addr,
  output logic [LUT_WIDTH-1:0]               lut_wr_data
);

  localparam int                 c_IDX_W    = clog2(NUM_NEURON) + 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_NEURON - 1);

  state_t                              r_state;
  state_t                              w_state_next;
  logic [c_IDX_W-1:0]                  r_index;
  logic [NUM_NEURON*LUT_ADDR_SIZE-1:0] r_snapshot;
  logic [NUM_NEURON*LUT_WIDTH-1:0]     r_outputs;
  logic                                r_wr_en;
  logic [LUT_ADDR_SIZE-1:0]            r_wr_addr;
  logic [LUT_WIDTH-1:0]                r_wr_data;
  logic                                w_cap_valid;
  logic [c_IDX_W-1:0]                  w_cap_idx;
  logic                                w_accept_start;
  logic                                w_accept_wr;

  assign w_accept_start = (r_state == ST_IDLE) && start;
  assign w_accept_wr    = cfg_wr_valid && cfg_wr_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: issue all reads, then wait for the last tag to come back
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_ISSUE;
      ST_ISSUE: if (r_index == c_LAST_IDX) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_cap_valid && (w_cap_idx == c_LAST_IDX)) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; start wins over a same-cycle host write
  always_comb begin
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
    lut_rd_en    = (r_state == ST_ISSUE);
    cfg_wr_ready = (r_state == ST_IDLE) && !start;
    lut_rd_addr  = r_snapshot[int'(r_index)*LUT_ADDR_SIZE +: LUT_ADDR_SIZE];
  end

  // Snapshot addresses on accepted start and walk the read index (no wrap)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snapshot <= '0;
      r_index    <= '0;
    end else if (w_accept_start) begin
      r_snapshot <= inputs;
      r_index    <= '0;
    end else if ((r_state == ST_ISSUE) && (r_index != c_LAST_IDX)) begin
      r_index <= r_index + 1'b1;
    end
  end

  activation_rd_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .IDX_W        (c_IDX_W)
  ) u_rd_pipe (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (lut_rd_en),
    .issue_idx     (r_index),
    .capture_valid (w_cap_valid),
    .capture_idx   (w_cap_idx)
  );

  // Land each returned word in its neuron slot; other slots keep old data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outputs <= '0;
    end else if (w_cap_valid) begin
      r_outputs[int'(w_cap_idx)*LUT_WIDTH +: LUT_WIDTH] <= lut_rd_data;
    end
  end

  assign outputs = r_outputs;

  // One registered stage between host handshake and the BRAM write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept_wr;
      if (w_accept_wr) begin
        r_wr_addr <= cfg_wr_addr;
        r_wr_data <= cfg_wr_data;
      end
    end
  end

  assign lut_wr_en   = r_wr_en;
  assign lut_wr_addr = r_wr_addr;
  assign lut_wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_activation_lut_scheduler.sv
// ============================================================================
// Module      : tb_activation_lut_scheduler
// Description : Self-checking bench; two schedulers (read latency 1 and 3)
//               share stimulus, each with its own BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_activation_lut_scheduler;

  localparam int N    = 6;
  localparam int AW   = 10;
  localparam int DW   = 9;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int JMAX = N + LAT1 + 3;

  typedef struct packed {
    logic [N-1:0][AW-1:0] a;
    logic [N-1:0][DW-1:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [N*AW-1:0] inputs;
  logic cfg_valid;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic mem_init;

  logic busy0, done0, rd_en0, ready0, wr_en0;
  logic busy1, done1, rd_en1, ready1, wr_en1;
  logic [N*DW-1:0] outs0, outs1;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [DW-1:0] rd_data0, rd_data1, wr_data0, wr_data1;

  logic [1:0] busy_v, done_v, rd_en_v, ready_v, wr_en_v;
  logic [1:0][N*DW-1:0] outs_v;
  logic [1:0][AW-1:0] rd_addr_v, wr_addr_v;
  logic [1:0][DW-1:0] wr_data_v;

  assign busy_v    = {busy1, busy0};
  assign done_v    = {done1, done0};
  assign rd_en_v   = {rd_en1, rd_en0};
  assign ready_v   = {ready1, ready0};
  assign wr_en_v   = {wr_en1, wr_en0};
  assign outs_v    = {outs1, outs0};
  assign rd_addr_v = {rd_addr1, rd_addr0};
  assign wr_addr_v = {wr_addr1, wr_addr0};
  assign wr_data_v = {wr_data1, wr_data0};

  activation_lut_scheduler #(.NUM_NEURON(N), .LUT_ADDR_SIZE(AW), .LUT_WIDTH(DW), .READ_LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .inputs(inputs), .busy(busy0), .done(done0),
    .outputs(outs0), .lut_rd_en(rd_en0), .lut_rd_addr(rd_addr0), .lut_rd_data(rd_data0),
    .cfg_wr_valid(cfg_valid), .cfg_wr_ready(ready0), .cfg_wr_addr(cfg_addr), .cfg_wr_data(cfg_data),
    .lut_wr_en(wr_en0), .lut_wr_addr(wr_addr0), .lut_wr_data(wr_data0)
  );

  activation_lut_scheduler #(.NUM_NEURON(N), .LUT_ADDR_SIZE(AW), .LUT_WIDTH(DW), .READ_LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .inputs(inputs), .busy(busy1), .done(done1),
    .outputs(outs1), .lut_rd_en(rd_en1), .lut_rd_addr(rd_addr1), .lut_rd_data(rd_data1),
    .cfg_wr_valid(cfg_valid), .cfg_wr_ready(ready1), .cfg_wr_addr(cfg_addr), .cfg_wr_data(cfg_data),
    .lut_wr_en(wr_en1), .lut_wr_addr(wr_addr1), .lut_wr_data(wr_data1)
  );

  // BRAM models: registered read with LAT0 / LAT1 stages, write port
  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];
  logic [DW-1:0] pipe0;
  logic [DW-1:0] pipe1 [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 1024; a++) begin
        mem0[a] <= DW'(a) ^ 9'h0AA;
        mem1[a] <= DW'(a) ^ 9'h0AA;
      end
    end else begin
      if (wr_en0) mem0[wr_addr0] <= wr_data0;
      if (wr_en1) mem1[wr_addr1] <= wr_data1;
    end
    pipe0    <= mem0[rd_addr0];
    pipe1[0] <= mem1[rd_addr1];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  assign rd_data0 = pipe0;
  assign rd_data1 = pipe1[2];

  always #5 clk = ~clk;

  // Reference LUT contents as the host sees them
  logic [DW-1:0] ref_lut [1024];
  int tests = 0;
  int fails = 0;
  bit pend;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  vec_t vecs [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0][AW-1:0] rand_addrs();
    logic [N-1:0][AW-1:0] v;
    for (int i = 0; i < N; i++) v[i] = AW'($urandom);
    return v;
  endfunction

  function automatic logic [N-1:0][DW-1:0] lut_of(input logic [N-1:0][AW-1:0] a);
    logic [N-1:0][DW-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ref_lut[a[i]];
    return v;
  endfunction

  // Idle cycles: no pass activity, pending host write must appear once
  task automatic idle_cycles(input int n, input bit outs_zero);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_valid = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("idle_busy%0d", d), 64'(busy_v[d]), 64'(0));
        check($sformatf("idle_done%0d", d), 64'(done_v[d]), 64'(0));
        check($sformatf("idle_rd_en%0d", d), 64'(rd_en_v[d]), 64'(0));
        check($sformatf("idle_wr_en%0d", d), 64'(wr_en_v[d]), 64'(pend));
        if (pend) check($sformatf("idle_wr_data%0d", d), 64'({wr_addr_v[d], wr_data_v[d]}), 64'({pend_addr, pend_data}));
        if (outs_zero) check($sformatf("idle_outs%0d", d), 64'(outs_v[d]), 64'(0));
      end
      pend = 1'b0;
    end
  endtask

  // Back-to-back host writes while idle
  task automatic cfg_writes(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a = AW'($urandom);
      v = DW'($urandom);
      start = 1'b0;
      cfg_valid = 1'b1;
      cfg_addr = a;
      cfg_data = v;
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cfg_ready%0d", d), 64'(ready_v[d]), 64'(1));
        check($sformatf("cfg_wr_en%0d", d), 64'(wr_en_v[d]), 64'(pend));
        if (pend) check($sformatf("cfg_wr_data%0d", d), 64'({wr_addr_v[d], wr_data_v[d]}), 64'({pend_addr, pend_data}));
      end
      ref_lut[a] = v;
      pend = 1'b1;
      pend_addr = a;
      pend_data = v;
    end
  endtask

  // One pass from T0 (j=0) with per-cycle expectations derived from timing rules
  task automatic run_pass(input logic [N-1:0][AW-1:0] addrs, input logic [N-1:0][DW-1:0] exp,
                          input bit hold_start, input bit scramble, input bit cfg_hold,
                          input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    bit acc_prev [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    bit idle;
    int lat;
    for (int d = 0; d < 2; d++) begin
      acc_prev[d] = pend;
      pa[d] = pend_addr;
      pd[d] = pend_data;
    end
    for (int j = 0; j <= JMAX; j++) begin
      @(negedge clk);
      start = (j == 0) || (hold_start && (j <= N + 2));
      if (j == 0) inputs = addrs;
      else if (scramble) inputs = rand_addrs();
      cfg_valid = cfg_hold;
      cfg_addr = ca;
      cfg_data = cd;
      #1;
      for (int d = 0; d < 2; d++) begin
        lat = lat_of(d);
        idle = !((j >= 1) && (j <= N + lat + 1));
        check($sformatf("busy%0d_j%0d", d, j), 64'(busy_v[d]), 64'(!idle));
        check($sformatf("done%0d_j%0d", d, j), 64'(done_v[d]), 64'(j == N + lat + 1));
        check($sformatf("rd_en%0d_j%0d", d, j), 64'(rd_en_v[d]), 64'((j >= 1) && (j <= N)));
        if ((j >= 1) && (j <= N))
          check($sformatf("rd_addr%0d_j%0d", d, j), 64'(rd_addr_v[d]), 64'(addrs[j-1]));
        if (j == N + lat + 1)
          check($sformatf("outputs%0d", d), 64'(outs_v[d]), 64'(exp));
        check($sformatf("ready%0d_j%0d", d, j), 64'(ready_v[d]), 64'(idle && !start));
        check($sformatf("wr_en%0d_j%0d", d, j), 64'(wr_en_v[d]), 64'(acc_prev[d]));
        if (acc_prev[d])
          check($sformatf("wr_data%0d_j%0d", d, j), 64'({wr_addr_v[d], wr_data_v[d]}), 64'({pa[d], pd[d]}));
        acc_prev[d] = cfg_valid && idle && !start;
        pa[d] = cfg_addr;
        pd[d] = cfg_data;
      end
    end
    pend = acc_prev[0];
    pend_addr = pa[0];
    pend_data = pd[0];
  endtask

  initial begin
    logic [N-1:0][AW-1:0] ad;
    rst = 1'b0;
    mem_init = 1'b1;
    start = 1'b0;
    inputs = '0;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    pend = 1'b0;
    pend_addr = '0;
    pend_data = '0;
    for (int a = 0; a < 1024; a++) ref_lut[a] = DW'(a) ^ 9'h0AA;

    vecs[0].a = {10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0};
    vecs[0].e = {9'h0AF, 9'h0AE, 9'h0A9, 9'h0A8, 9'h0AB, 9'h0AA};
    vecs[1].a = {10'd1000, 10'd85, 10'd170, 10'd256, 10'd512, 10'd1023};
    vecs[1].e = {9'h142, 9'h0FF, 9'h000, 9'h1AA, 9'h0AA, 9'h155};

    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst = 1'b1;

    // Reset state held through a quiet idle period
    idle_cycles(20, 1'b1);

    // Directed table vectors
    for (int v = 0; v < 2; v++) run_pass(vecs[v].a, vecs[v].e, 1'b0, 1'b0, 1'b0, '0, '0);

    // Host write raised together with start: held off until the pass ends
    ad = {10'd3, 10'd7, 10'd2, 10'd7, 10'd1, 10'd7};
    run_pass(ad, lut_of(ad), 1'b0, 1'b0, 1'b1, 10'd7, 9'h1FF);
    ref_lut[7] = 9'h1FF;
    idle_cycles(2, 1'b0);
    run_pass(ad, lut_of(ad), 1'b0, 1'b0, 1'b0, '0, '0);

    // start held for the whole pass with inputs scrambled after T0
    run_pass(vecs[1].a, vecs[1].e, 1'b1, 1'b1, 1'b0, '0, '0);

    // Asynchronous reset in the middle of a pass
    @(negedge clk);
    start = 1'b1;
    cfg_valid = 1'b0;
    inputs = vecs[0].a;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy%0d", d), 64'(busy_v[d]), 64'(0));
      check($sformatf("rst_done%0d", d), 64'(done_v[d]), 64'(0));
      check($sformatf("rst_outs%0d", d), 64'(outs_v[d]), 64'(0));
      check($sformatf("rst_rd_en%0d", d), 64'(rd_en_v[d]), 64'(0));
      check($sformatf("rst_wr_en%0d", d), 64'(wr_en_v[d]), 64'(0));
    end
    @(negedge clk);
    rst = 1'b1;
    pend = 1'b0;
    idle_cycles(12, 1'b1);
    run_pass(vecs[0].a, vecs[0].e, 1'b0, 1'b0, 1'b0, '0, '0);

    // Randomized host writes and passes against the reference LUT
    for (int it = 0; it < 20; it++) begin
      cfg_writes($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycles(1, 1'b0);
      ad = rand_addrs();
      if ($urandom_range(0, 3) == 0) ad[$urandom_range(0, N-1)] = pend_addr;
      run_pass(ad, lut_of(ad), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, '0, '0);
    end
    idle_cycles(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
